// File: rtl/mem_responder.sv
// Behavioural memory responder: line-fill / single-word reads with a fixed
// return latency, and single-cycle commit of strobed or full-line writes.
module mem_responder #(
  parameter int BYTES_PER_LINE = 16,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_LATENCY  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_req,
  input  logic [31:0]                 rd_addr,
  input  logic [1:0]                  rd_size,
  input  logic                        burst,
  output logic                        rd_rdy,
  output logic                        ret_valid,
  output logic                        ret_last,
  output logic [31:0]                 ret_data,
  input  logic                        wr_req,
  input  logic [31:0]                 wr_addr,
  input  logic [3:0]                  wr_strb,
  input  logic [1:0]                  wr_size,
  input  logic                        wr_burst,
  input  logic [BYTES_PER_LINE*8-1:0] wr_data,
  output logic                        wr_rdy
);

  localparam int WPL  = BYTES_PER_LINE / 4;
  localparam int AW   = $clog2(MEM_WORDS);
  localparam int LW   = $clog2(WPL);
  localparam int ROWS = MEM_WORDS / WPL;
  localparam int BCW  = (LW > 0) ? LW : 1;
  localparam int LCW  = $clog2(READ_LATENCY + 1);
  localparam int WCW  = $clog2(WRITE_LATENCY + 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(WPL - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RET  = 2'd2
  } rd_state_t;

  rd_state_t              state_reg;
  rd_state_t              state_next;
  logic [LCW-1:0]         lat_cnt_reg;
  logic [BCW-1:0]         beat_reg;
  logic [AW-1:0]          base_reg;
  logic                   burst_reg;
  logic [WCW-1:0]         wr_cnt_reg;

  logic [AW-1:0]          rd_idx;
  logic [AW-1:0]          wr_idx;
  logic [AW-LW-1:0]       wr_row;
  logic [AW-1:0]          rd_word;
  logic [AW-LW-1:0]       rd_row;
  logic [WPL-1:0][31:0]   bank_rdata;
  logic [31:0]            rd_word_data;
  logic                   rd_accept;
  logic                   wr_commit;
  logic                   beat_last;
  logic                   lat_done;
  logic                   unused_ok;

  assign rd_idx    = rd_addr[2 +: AW];
  assign wr_idx    = wr_addr[2 +: AW];
  assign wr_row    = wr_idx[AW-1:LW];
  assign rd_accept = rd_req & rd_rdy;
  assign wr_commit = wr_req & ~reset;
  assign beat_last = ~burst_reg | (beat_reg == BCW'(WPL - 1));
  assign lat_done  = (lat_cnt_reg == '0);

  // Sizes and address bits outside the word index are intentionally ignored.
  assign unused_ok = ^{rd_size, wr_size, rd_addr[1:0], rd_addr[31:AW+2],
                       wr_addr[1:0], wr_addr[31:AW+2]};

  // ------------------------------------------------------------------
  // Read FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= R_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      R_IDLE: begin
        if (rd_accept) begin
          state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_done) begin
          state_next = R_RET;
        end
      end
      R_RET: begin
        if (beat_last) begin
          state_next = R_IDLE;
        end
      end
      default: begin
        state_next = R_IDLE;
      end
    endcase
  end

  // Read FSM: outputs; beat data comes straight from the banks so any write
  // committed at an earlier edge is already visible.
  always_comb begin
    rd_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = 32'd0;
    if (!reset && state_reg == R_IDLE && !wr_req) begin
      rd_rdy = 1'b1;
    end
    if (state_reg == R_RET) begin
      ret_valid = 1'b1;
      ret_last  = beat_last;
      ret_data  = rd_word_data;
    end
  end

  // Latency and beat counters; the wait state lasts READ_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt_reg <= '0;
      beat_reg    <= '0;
    end else begin
      if (rd_accept) begin
        lat_cnt_reg <= LCW'(READ_LATENCY - 1);
        beat_reg    <= '0;
      end else begin
        if (state_reg == R_WAIT && !lat_done) begin
          lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end
        if (state_reg == R_RET && !beat_last) begin
          beat_reg <= beat_reg + 1'b1;
        end
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      base_reg  <= burst ? (rd_idx & ~LINE_MASK) : rd_idx;
      burst_reg <= burst;
    end
  end

  // ------------------------------------------------------------------
  // Write engine busy window
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_reg <= '0;
    end else if (wr_commit) begin
      wr_cnt_reg <= WCW'(WRITE_LATENCY);
    end else if (wr_cnt_reg != '0) begin
      wr_cnt_reg <= wr_cnt_reg - 1'b1;
    end
  end

  assign wr_rdy = (wr_cnt_reg == '0);

  // ------------------------------------------------------------------
  // Storage: one bank per line word so a whole line commits in one edge
  // ------------------------------------------------------------------
  assign rd_word = base_reg + AW'(beat_reg);
  assign rd_row  = rd_word[AW-1:LW];

  genvar gi;
  generate
    for (gi = 0; gi < WPL; gi++) begin : g_bank
      logic [31:0] mem [ROWS];
      logic        bank_hit;

      assign bank_hit = ((wr_idx & LINE_MASK) == AW'(gi));

      always_ff @(posedge clk) begin
        if (wr_commit) begin
          if (wr_burst) begin
            mem[wr_row] <= wr_data[gi*32 +: 32];
          end else if (bank_hit) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) begin
                mem[wr_row][b*8 +: 8] <= wr_data[b*8 +: 8];
              end
            end
          end
        end
      end

      assign bank_rdata[gi] = mem[rd_row];
    end
  endgenerate

  always_comb begin
    rd_word_data = 32'd0;
    for (int b = 0; b < WPL; b++) begin
      if ((rd_word & LINE_MASK) == AW'(b)) begin
        rd_word_data = bank_rdata[b];
      end
    end
  end

endmodule
